axis_i2c_master: RTL and testbench

// - Single-byte I2C bus master driven by an AXI-Stream command port.
// - Each accepted AXIS beat (address, R/W, data) runs one complete I2C transaction:

---
 rtl/axis_i2c_pkg.sv | 12 +
 rtl/i2c_quarter_tick.sv | 26 ++
 rtl/axis_i2c_master.sv | 152 +++++++++++++++
 tb/tb_axis_i2c_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_i2c_pkg.sv
// Shared widths, bus timing and controller states for the AXIS-driven I2C master.
package axis_i2c_pkg;
  localparam int AXIS_DATA_WIDTH    = 16;
  localparam int I2C_DATA_WIDTH     = 8;
  localparam int SYS_CLK_FREQ       = 50_000_000;
  localparam int I2C_FREQ           = 100_000;
  localparam int SCL_QUARTER_CYCLES = SYS_CLK_FREQ / I2C_FREQ / 4;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, WRITE, ACK_W, READ, MNACK, STOP
  } i2c_state_t;
endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period strobe: down-counter reloaded while disabled, one-cycle tick at terminal count.
module i2c_quarter_tick #(
  parameter int QUARTER_CYCLES = 125
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(QUARTER_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(QUARTER_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      cnt <= '0;
    end else if (!en || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);
endmodule

// File: rtl/axis_i2c_master.sv
// Single-byte I2C master: each AXIS beat {addr, rw, data} runs START, address, one data byte, STOP.
//
// state | meaning
// IDLE  | bus released, tready high, waiting for a command beat
// START | SDA pulled low under high SCL for two quarters, then SCL low
// ADDR  | shifting out {addr, rw}, MSB first
// ACK_A | SDA released, slave address acknowledge sampled
// WRITE | shifting out the write byte, MSB first
// ACK_W | SDA released, slave data acknowledge sampled (outcome ignored)
// READ  | SDA released, shifting in the slave byte, MSB first
// MNACK | master leaves SDA high on the ninth bit to end the read
// STOP  | SDA low, SCL high, SDA released, one bus-free quarter
module axis_i2c_master #(
  parameter int SCL_QUARTER_CYCLES = axis_i2c_pkg::SCL_QUARTER_CYCLES
) (
  input  logic                                    clk_i,
  input  logic                                    arstn_i,
  output logic                                    i2c_scl_o,
  inout  wire                                     i2c_sda_io,
  output logic [axis_i2c_pkg::I2C_DATA_WIDTH-1:0]  i2c_rdata_o,
  output logic                                    rvalid_o,
  input  logic [axis_i2c_pkg::AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready
);
  import axis_i2c_pkg::*;

  i2c_state_t state, state_n;
  logic [1:0] qtr, qtr_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       scl_n, sda_low, sda_low_n, rvalid_n;
  logic       ready_en, tick, sda_in, handshake, tx_bit;
  logic [6:0] addr;
  logic       rw;
  logic [I2C_DATA_WIDTH-1:0] wdata, rx, rx_n, rdata_n, tx_byte;

  i2c_quarter_tick #(.QUARTER_CYCLES(SCL_QUARTER_CYCLES)) u_tick (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .en      (state != IDLE),
    .tick    (tick)
  );

  assign i2c_sda_io    = sda_low ? 1'b0 : 1'bz;
  assign sda_in        = i2c_sda_io;
  assign s_axis_tready = ready_en && (state == IDLE);
  assign handshake     = s_axis_tvalid && s_axis_tready;
  assign tx_byte       = (state == ADDR) ? {addr, rw} : wdata;
  assign tx_bit        = tx_byte[~bit_cnt];

  always_comb begin
    state_n   = state;
    qtr_n     = qtr;
    bit_cnt_n = bit_cnt;
    scl_n     = i2c_scl_o;
    sda_low_n = sda_low;
    rx_n      = rx;
    rdata_n   = i2c_rdata_o;
    rvalid_n  = 1'b0;
    if (state == IDLE) begin
      scl_n     = 1'b1;
      sda_low_n = 1'b0;
      qtr_n     = 2'd0;
      bit_cnt_n = 3'd0;
      if (handshake) state_n = START;
    end else if (tick) begin
      qtr_n = qtr + 2'd1;
      case (state)
        START: begin
          if (qtr == 2'd0) sda_low_n = 1'b1;
          if (qtr == 2'd2) begin
            scl_n   = 1'b0;
            qtr_n   = 2'd0;
            state_n = ADDR;
          end
        end
        STOP: begin
          case (qtr)
            2'd0:    sda_low_n = 1'b1;
            2'd1:    scl_n     = 1'b1;
            2'd2:    sda_low_n = 1'b0;
            default: state_n   = IDLE;
          endcase
        end
        default: begin
          // Bit slot: q0 drive SDA, q1 raise SCL, q3 sample and lower SCL.
          case (qtr)
            2'd0: begin
              scl_n     = 1'b0;
              sda_low_n = (state == ADDR || state == WRITE) ? !tx_bit : 1'b0;
            end
            2'd1: scl_n = 1'b1;
            2'd3: begin
              scl_n = 1'b0;
              case (state)
                ADDR, WRITE: begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state_n = (state == ADDR) ? ACK_A : ACK_W;
                end
                READ: begin
                  rx_n      = {rx[I2C_DATA_WIDTH-2:0], sda_in};
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state_n = MNACK;
                end
                ACK_A:   state_n = sda_in ? STOP : (rw ? READ : WRITE);
                MNACK: begin
                  state_n  = STOP;
                  rdata_n  = rx;
                  rvalid_n = 1'b1;
                end
                default: state_n = STOP;
              endcase
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      qtr         <= 2'd0;
      bit_cnt     <= 3'd0;
      i2c_scl_o   <= 1'b1;
      sda_low     <= 1'b0;
      rx          <= '0;
      i2c_rdata_o <= '0;
      rvalid_o    <= 1'b0;
      ready_en    <= 1'b0;
      addr        <= '0;
      rw          <= 1'b0;
      wdata       <= '0;
    end else begin
      state       <= state_n;
      qtr         <= qtr_n;
      bit_cnt     <= bit_cnt_n;
      i2c_scl_o   <= scl_n;
      sda_low     <= sda_low_n;
      rx          <= rx_n;
      i2c_rdata_o <= rdata_n;
      rvalid_o    <= rvalid_n;
      ready_en    <= 1'b1;
      if (handshake) begin
        addr  <= s_axis_tdata[15:9];
        rw    <= s_axis_tdata[8];
        wdata <= s_axis_tdata[7:0];
      end
    end
  end
endmodule

// File: tb/tb_axis_i2c_master.sv
// Bench for axis_i2c_master: bus monitor plus slave model feeding a token scoreboard.
module tb_axis_i2c_master;
  localparam int Q = 4;
  localparam logic [11:0] T_START = 12'h400;
  localparam logic [11:0] T_STOP  = 12'h800;

  logic        clk = 1'b0;
  logic        arstn;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready, scl, rvalid;
  logic [7:0]  rdata;
  logic        slave_low;
  wire         sda;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  axis_i2c_master #(.SCL_QUARTER_CYCLES(Q)) dut (
    .clk_i         (clk),
    .arstn_i       (arstn),
    .i2c_scl_o     (scl),
    .i2c_sda_io    (sda),
    .i2c_rdata_o   (rdata),
    .rvalid_o      (rvalid),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [11:0] exp_q[$];

  // Slave/monitor state
  logic       mon_off = 1'b1;
  logic       ack_addr = 1'b1;
  logic [7:0] rd_byte = 8'hC3;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_rv = 1'b0;
  logic       busy = 1'b0, saw_ready = 1'b0, rw_bit = 1'b0;
  logic [8:0] sh = '0;
  int         bitn = 0, byte_idx = 0, cyc = 0, stop_cyc = -1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic got(input logic [11:0] tok);
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got %h expected none", tok);
    end else begin
      logic [11:0] e;
      e = exp_q.pop_front();
      if (e !== tok) begin
        fails++;
        $display("FAIL bus_event: got %h expected %h", tok, e);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_off) begin
      prev_scl = 1'b1; prev_sda = 1'b1; prev_rv = 1'b0;
      bitn = 0; byte_idx = 0; busy = 1'b0; slave_low = 1'b0;
    end else begin
      logic s_c, s_d;
      s_c = scl;
      s_d = sda;
      if (prev_scl && s_c && prev_sda && !s_d) begin
        got(T_START);
        if (stop_cyc >= 0) chk("bus_free_gap_ok", 16'(cyc - stop_cyc >= 2 * Q), 16'd1);
        busy = 1'b1; saw_ready = 1'b0; bitn = 0; byte_idx = 0; slave_low = 1'b0;
      end else if (prev_scl && s_c && !prev_sda && s_d) begin
        got(T_STOP);
        chk("tready_low_while_busy", 16'(saw_ready), 16'd0);
        busy = 1'b0; stop_cyc = cyc;
      end else if (!prev_scl && s_c) begin
        sh = {sh[7:0], s_d};
        bitn++;
        if (bitn == 9) begin
          got({3'b000, sh[0], sh[8:1]});
          if (byte_idx == 0) rw_bit = sh[1];
          byte_idx++;
          bitn = 0;
        end
      end else if (prev_scl && !s_c) begin
        if (bitn == 8) begin
          if (byte_idx == 0) slave_low = ack_addr;
          else if (byte_idx == 1 && !rw_bit) slave_low = 1'b1;
          else slave_low = 1'b0;
        end else if (byte_idx == 1 && rw_bit && ack_addr) begin
          slave_low = !rd_byte[7 - bitn];
        end else begin
          slave_low = 1'b0;
        end
      end
      if (busy && tready) saw_ready = 1'b1;
      if (rvalid) begin
        got({4'hC, rdata});
        if (prev_rv) begin
          tests++; fails++;
          $display("FAIL rvalid_width: got 2+ cycles expected 1");
        end
      end
      prev_scl = s_c; prev_sda = s_d; prev_rv = rvalid;
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!tready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 16'(tready), 16'd1);
  endtask

  task automatic send(input logic [15:0] d);
    tdata  = d;
    tvalid = 1'b1;
    wait_ready("handshake_timeout");
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && tready) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 16'(exp_q.size()), 16'd0);
    chk({name, "_tready"}, 16'(tready), 16'd1);
    exp_q.delete();
  endtask

  initial begin
    arstn = 1'b0; tdata = '0; tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl", 16'(scl), 16'd1);
    chk("rst_sda", 16'(sda), 16'd1);
    chk("rst_rvalid", 16'(rvalid), 16'd0);
    chk("rst_rdata", 16'(rdata), 16'd0);
    chk("rst_tready", 16'(tready), 16'd0);
    arstn = 1'b1;
    @(negedge clk);
    chk("rel_tready", 16'(tready), 16'd1);
    mon_off = 1'b0;
    @(negedge clk);

    // Write 0x5A to 0x50
    exp_q = '{T_START, 12'h0A0, 12'h05A, T_STOP};
    send(16'hA05A);
    wait_done("write");
    chk("write_rdata", 16'(rdata), 16'd0);

    // Read 0xC3 from 0x50
    exp_q = '{T_START, 12'h0A1, 12'h1C3, 12'hCC3, T_STOP};
    send(16'hA100);
    wait_done("read");
    chk("read_rdata", 16'(rdata), 16'h00C3);

    // Address NACK
    ack_addr = 1'b0;
    exp_q = '{T_START, 12'h190, T_STOP};
    send(16'h9000);
    wait_done("nack");
    chk("nack_rdata_held", 16'(rdata), 16'h00C3);
    ack_addr = 1'b1;

    // Back-to-back with tvalid held
    exp_q = '{T_START, 12'h0A0, 12'h011, T_STOP, T_START, 12'h0A0, 12'h022, T_STOP};
    tdata = 16'hA011; tvalid = 1'b1;
    wait_ready("b2b_first");
    @(negedge clk);
    tdata = 16'hA022;
    chk("b2b_tready_drop", 16'(tready), 16'd0);
    wait_ready("b2b_second");
    @(negedge clk);
    tvalid = 1'b0;
    wait_done("b2b");

    // Reset during the address phase
    exp_q = '{T_START};
    send(16'hA055);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("midrst_start_seen", 16'(exp_q.size()), 16'd0);
    end
    repeat (14) @(negedge clk);
    mon_off = 1'b1;
    arstn = 1'b0;
    @(negedge clk);
    chk("midrst_scl", 16'(scl), 16'd1);
    chk("midrst_sda", 16'(sda), 16'd1);
    chk("midrst_tready", 16'(tready), 16'd0);
    chk("midrst_rdata", 16'(rdata), 16'd0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle", 16'(tready), 16'd1);
    mon_off = 1'b0;
    @(negedge clk);
    exp_q = '{T_START, 12'h0A0, 12'h077, T_STOP};
    send(16'hA077);
    wait_done("post_reset_write");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
